// File: rtl/maze_pkg.sv
// Shared maze definitions: tile codes, loader states and default map size.
package maze_pkg;

    typedef enum logic [1:0] {
        I_NONE      = 2'd0,
        I_DOT       = 2'd1,
        I_ENERGIZER = 2'd2,
        I_FRUIT     = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int MAP_ROWS_DEF = 36;
    localparam int MAP_COLS_DEF = 28;

endpackage

// File: rtl/fruit_timer.sv
// Bonus fruit control: spawns on eaten-count thresholds (each once per load),
// counts down its lifetime in frame ticks and flags expiry.
module fruit_timer #(
    parameter int CNT_W    = 10,
    parameter int THRESH_0 = 70,
    parameter int THRESH_1 = 170,
    parameter int TICKS    = 600,
    localparam int TMR_W   = $clog2(TICKS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] items_eaten,
    input  logic             tick,
    input  logic             fruit_eaten,
    output logic             spawn,
    output logic             expire
);

    logic             fired_0;
    logic             fired_1;
    logic             hit_0;
    logic             hit_1;
    logic [TMR_W-1:0] timer;

    // Compare against the registered count, so the fruit lands one cycle
    // after the count reaches a threshold.
    assign hit_0  = !clear && !fired_0 && (items_eaten == CNT_W'(THRESH_0));
    assign hit_1  = !clear && !fired_1 && (items_eaten == CNT_W'(THRESH_1));
    assign spawn  = hit_0 || hit_1;
    // Expiry is the tick that takes the timer from 1 to 0; a spawn in the same
    // cycle reloads the timer instead.
    assign expire = !clear && !spawn && tick && (timer == TMR_W'(1));

    // Once-per-load flags and lifetime down-counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fired_0 <= 1'b0;
            fired_1 <= 1'b0;
            timer   <= '0;
        end else if (clear) begin
            fired_0 <= 1'b0;
            fired_1 <= 1'b0;
            timer   <= '0;
        end else begin
            fired_0 <= fired_0 || hit_0;
            fired_1 <= fired_1 || hit_1;
            if (spawn)
                timer <= TMR_W'(TICKS);
            else if (fruit_eaten)
                timer <= '0;
            else if (tick && timer != '0)
                timer <= timer - TMR_W'(1);
        end
    end

endmodule

// File: rtl/maze_item_store.sv
// Maze item map: streams the layout from the tile ROM, services eat requests
// from the mover, keeps dot/energizer/eaten counters and hosts the bonus fruit.
module maze_item_store
    import maze_pkg::*;
#(
    parameter int MAP_ROWS       = MAP_ROWS_DEF,
    parameter int MAP_COLS       = MAP_COLS_DEF,
    parameter int ROM_LATENCY    = 1,
    parameter int FRUIT_THRESH_0 = 70,
    parameter int FRUIT_THRESH_1 = 170,
    parameter int FRUIT_ROW      = 20,
    parameter int FRUIT_COL      = 13,
    parameter int FRUIT_TICKS    = 600,
    localparam int N             = MAP_ROWS * MAP_COLS,
    localparam int ADDR_W        = $clog2(N),
    localparam int CNT_W         = $clog2(N + 1),
    localparam int ROW_W         = $clog2(MAP_ROWS),
    localparam int COL_W         = $clog2(MAP_COLS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_reload,
    output logic [ADDR_W-1:0]  o_rom_addr,
    input  logic [1:0]         i_rom_data,
    input  logic               i_eat_valid,
    input  logic [ROW_W-1:0]   i_eat_row,
    input  logic [COL_W-1:0]   i_eat_col,
    output logic               o_eat_done,
    output logic [1:0]         o_eat_type,
    output logic [2*N-1:0]     o_items,
    output logic               o_busy,
    output logic               o_reload_done,
    output logic [CNT_W-1:0]   o_dots_left,
    output logic [CNT_W-1:0]   o_items_eaten,
    output logic [CNT_W-1:0]   o_energizers_left,
    output logic               o_fruit_active,
    output logic               o_level_clear
);

    localparam int FRUIT_IDX = FRUIT_ROW * MAP_COLS + FRUIT_COL;

    state_t                           state;
    logic                             loaded;
    logic [ADDR_W-1:0]                addr;
    logic [N-1:0][1:0]                map;
    logic [ROM_LATENCY:1]             vld_pipe;
    logic [ROM_LATENCY:1][ADDR_W-1:0] addr_pipe;

    logic              issue_vld;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [1:0]        wr_tile;
    logic              in_range;
    logic [ADDR_W-1:0] eat_idx;
    logic [1:0]        old_tile;
    logic              eat_acc;
    logic              eat_hit;
    logic              fruit_eaten;
    logic              spawn;
    logic              expire;

    // ROM return path: the last pipeline stage lines up with i_rom_data.
    // A restart drops whatever is still in flight, including this cycle's data.
    assign issue_vld = (state == S_FETCH);
    assign wr_en     = vld_pipe[ROM_LATENCY] && !i_reload;
    assign wr_idx    = addr_pipe[ROM_LATENCY];
    assign wr_tile   = (i_rom_data == I_FRUIT) ? I_NONE : i_rom_data;

    // Completion is flagged during the cycle whose edge writes the last tile,
    // which is also the last busy cycle.
    assign o_reload_done = (state == S_DRAIN) && wr_en && (wr_idx == ADDR_W'(N - 1));

    // Eat decode; out-of-range coordinates still complete, as a NONE eat.
    assign in_range    = ({1'b0, i_eat_row} < (ROW_W + 1)'(MAP_ROWS)) &&
                         ({1'b0, i_eat_col} < (COL_W + 1)'(MAP_COLS));
    assign eat_idx     = ADDR_W'(i_eat_row) * ADDR_W'(MAP_COLS) + ADDR_W'(i_eat_col);
    assign old_tile    = in_range ? map[eat_idx] : I_NONE;
    assign eat_acc     = i_eat_valid && (state == S_IDLE) && !i_reload;
    assign eat_hit     = eat_acc && in_range;
    assign fruit_eaten = eat_hit && (old_tile == I_FRUIT);

    assign o_rom_addr     = addr;
    assign o_items        = map;
    assign o_busy         = (state != S_IDLE);
    assign o_fruit_active = (map[FRUIT_IDX] == I_FRUIT);
    assign o_level_clear  = loaded && (state == S_IDLE) &&
                            (o_dots_left == '0) && (o_energizers_left == '0);

    // Loader FSM: a reload pulse restarts from address 0 from any state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            addr   <= '0;
            loaded <= 1'b0;
        end else if (i_reload) begin
            state  <= S_FETCH;
            addr   <= '0;
            loaded <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (addr == ADDR_W'(N - 1))
                        state <= S_DRAIN;
                    else
                        addr <= addr + ADDR_W'(1);
                end
                S_DRAIN: begin
                    if (o_reload_done) begin
                        state  <= S_IDLE;
                        addr   <= '0;
                        loaded <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid/address shift register matching the ROM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (i_reload) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1]  <= issue_vld;
            addr_pipe[1] <= addr;
            for (int j = 2; j <= ROM_LATENCY; j++) begin
                vld_pipe[j]  <= vld_pipe[j-1];
                addr_pipe[j] <= addr_pipe[j-1];
            end
        end
    end

    // Map writes; a spawn is applied last so it wins over any clear of that tile.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            map <= '0;
        end else if (i_reload) begin
            map[FRUIT_IDX] <= I_NONE;
        end else begin
            if (wr_en)
                map[wr_idx] <= wr_tile;
            if (eat_hit)
                map[eat_idx] <= I_NONE;
            if (expire)
                map[FRUIT_IDX] <= I_NONE;
            if (spawn)
                map[FRUIT_IDX] <= I_FRUIT;
        end
    end

    // Item counters, saturating in both directions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dots_left       <= '0;
            o_energizers_left <= '0;
            o_items_eaten     <= '0;
        end else if (i_reload) begin
            o_dots_left       <= '0;
            o_energizers_left <= '0;
            o_items_eaten     <= '0;
        end else begin
            if (wr_en) begin
                if (wr_tile == I_DOT && o_dots_left != '1)
                    o_dots_left <= o_dots_left + CNT_W'(1);
                if (wr_tile == I_ENERGIZER && o_energizers_left != '1)
                    o_energizers_left <= o_energizers_left + CNT_W'(1);
            end
            if (eat_hit && (old_tile == I_DOT || old_tile == I_ENERGIZER)) begin
                if (o_items_eaten != '1)
                    o_items_eaten <= o_items_eaten + CNT_W'(1);
                if (old_tile == I_DOT && o_dots_left != '0)
                    o_dots_left <= o_dots_left - CNT_W'(1);
                if (old_tile == I_ENERGIZER && o_energizers_left != '0)
                    o_energizers_left <= o_energizers_left - CNT_W'(1);
            end
        end
    end

    // Eat response: one-cycle done pulse, type held until the next accepted eat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_eat_done <= 1'b0;
            o_eat_type <= I_NONE;
        end else begin
            o_eat_done <= eat_acc;
            if (eat_acc)
                o_eat_type <= old_tile;
        end
    end

    fruit_timer #(
        .CNT_W    (CNT_W),
        .THRESH_0 (FRUIT_THRESH_0),
        .THRESH_1 (FRUIT_THRESH_1),
        .TICKS    (FRUIT_TICKS)
    ) u_fruit (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .clear       (i_reload),
        .items_eaten (o_items_eaten),
        .tick        (i_tick),
        .fruit_eaten (fruit_eaten),
        .spawn       (spawn),
        .expire      (expire)
    );

endmodule

// File: doc/maze_item_store.md
# maze_item_store

Parametrised item map for the maze: loads dot/energizer layout from an external tile ROM, tracks eaten items, and spawns/expires the bonus fruit. It sits between the game FSM, the Pac-Man mover, and the renderer, which reads the flattened map. Counts are computed from ROM contents, so any maze size or layout works without constants.

## Interface
- MAP_ROWS, 36, tile rows
- MAP_COLS, 28, tile columns
- ROM_LATENCY, 1, cycles from o_rom_addr to valid i_rom_data (≥1)
- FRUIT_THRESH_0 / FRUIT_THRESH_1, 70 / 170, items-eaten counts that spawn fruit
- FRUIT_ROW / FRUIT_COL, 20 / 13, fruit tile
- FRUIT_TICKS, 600, fruit lifetime in i_tick pulses
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_tick  in  1  frame tick, one-cycle pulse
- i_reload  in  1  start reload pulse
- o_rom_addr  out  $clog2(MAP_ROWS*MAP_COLS)  tile address, row*MAP_COLS+col
- i_rom_data  in  2  tile code from ROM
- i_eat_valid  in  1  eat request
- i_eat_row / i_eat_col  in  ROW_W / COL_W  tile to eat
- o_eat_done  out  1  one-cycle pulse per accepted eat
- o_eat_type  out  2  previous tile code of eaten tile
- o_items  out  MAP_ROWS*MAP_COLS*2  map, tile k at bits [2k+1:2k]
- o_busy  out  1  reload in progress
- o_reload_done  out  1  one-cycle pulse at reload completion
- o_dots_left, o_items_eaten  out  CNT_W  counters, CNT_W=$clog2(MAP_ROWS*MAP_COLS+1)
- o_energizers_left  out  CNT_W  remaining energizers
- o_fruit_active  out  1  fruit tile currently FRUIT
- o_level_clear  out  1  loaded, idle, dots_left==0 and energizers_left==0

## Operation
- Tile codes: 0 NONE, 1 DOT, 2 ENERGIZER, 3 FRUIT. ROM value 3 loads as NONE.
- States: S_IDLE, S_FETCH, S_DRAIN.
- In S_IDLE, i_reload → S_FETCH. Entry clears all counters, fruit, and a `loaded` flag.
- S_FETCH issues addresses 0..N-1, one per cycle (N=MAP_ROWS*MAP_COLS).
  - A ROM_LATENCY-deep valid/address pipeline writes each returned tile.
  - Each write increments dots_left or energizers_left.
- After address N-1 → S_DRAIN until the pipeline empties → S_IDLE.
  - On that transition: o_reload_done pulses and `loaded` sets.
- i_reload in S_FETCH/S_DRAIN restarts at address 0 with counters cleared. In-flight pipeline entries are discarded.
- Eat (S_IDLE only; ignored while busy, no o_eat_done):
  - o_eat_type = old tile, tile → NONE, o_eat_done=1.
  - DOT: dots_left−1, items_eaten+1.
  - ENERGIZER: energizers_left−1, items_eaten+1.
  - FRUIT: timer cleared, o_fruit_active=0.
  - NONE: no counter change.
  - Coordinates ≥ MAP_ROWS/MAP_COLS: o_eat_done with type NONE, no change.
- Fruit spawn: registered compare, one cycle after items_eaten becomes equal to a threshold.
  - Fruit tile ← FRUIT, timer ← FRUIT_TICKS.
  - Each threshold fires at most once per load.
- Each i_tick decrements the timer. At 0 the tile ← NONE.
- Eat of the fruit tile in the same cycle as expiry: eat wins, o_eat_type=FRUIT.
- Counters saturate at 0 and never wrap.

## Timing
- Reset values: all outputs 0, map all NONE, state S_IDLE, loaded=0.
- Reset mid-reload aborts immediately.
- Reload:
  - o_busy rises the cycle after i_reload.
  - Duration N+ROM_LATENCY cycles; o_reload_done pulses on the last of them.
  - o_busy falls with o_reload_done.
- Eat latency: one cycle. Request at edge t → tile, counters, and o_eat_done visible after edge t+1.
- Back-to-back eats on consecutive cycles are all accepted.
- o_level_clear is combinational from registered counters.

## Structure
- Shared package `maze_pkg`:
  - tile_t enum {I_NONE, I_DOT, I_ENERGIZER, I_FRUIT}
  - state enum
  - default map dimensions
- Sub-module `fruit_timer`: spawn compare, once-per-load flags, tick down-counter, expire pulse.
- Map register array, ROM pipeline, and counters stay in the top.

## Test plan
- ROM with 220 DOT, 4 ENERGIZER, rest 0, ROM_LATENCY=2, pulse i_reload:
  - o_busy for 1010 cycles, then o_reload_done.
  - o_dots_left=220, o_energizers_left=4.
- Eat DOT at (4,1), then eat (4,1) again:
  - first: o_eat_type=1, dots_left 219, items_eaten 1.
  - second: type 0, counters unchanged.
- Eat out-of-range (40,5) and eat while busy:
  - out-of-range: o_eat_done with type 0, no change.
  - while busy: no o_eat_done.
- Eat 70 items → fruit at (20,13) one cycle later, o_fruit_active=1.
  - After 600 i_tick the tile is NONE.
  - Repeat with eat at tick 600: o_eat_type=3.
- i_reload at address 500 mid-load → counters restart, completion N+ROM_LATENCY cycles after the second i_reload.
- Eat all items → o_level_clear=1.
  - Assert i_rst_n=0 mid-reload → all outputs 0 asynchronously.
